// File: rtl/fast_event_pacer_pkg.sv
// Shared types and default sizes for the fast event pacer.
package fast_event_pacer_pkg;

  localparam int unsigned CNT_W_DEFAULT = 4;
  localparam int unsigned TMO_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down event counter with a sticky overflow flag.
// Simultaneous inc and dec cancel, so a release at saturation never drops an event.
module sat_updown_cnt
  import fast_event_pacer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count update; an increment at the ceiling is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc && !dec) begin
      if (count == CNT_MAX) begin
        overflow <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fast_event_pacer.sv
// Queues fastclk event strobes and releases them one at a time as a
// one-cycle request, waiting for the downstream ack to rise and fall.
// Optional watchdog: define FAST_EVENT_PACER_TIMEOUT_EN.
module fast_event_pacer
  import fast_event_pacer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT,
  parameter int unsigned TMO_W = TMO_W_DEFAULT
) (
  input  logic             fastclk,
  input  logic             rst,
  input  logic             event_in,
  input  logic             ack_pulse,
  output logic             fastpulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow,
  output logic             timeout
);

  state_t state;
  state_t state_next;
  logic   release_c;

  sat_updown_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (fastclk),
    .rst      (rst),
    .inc      (event_in),
    .dec      (release_c),
    .count    (pending),
    .overflow (overflow)
  );

`ifdef FAST_EVENT_PACER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit_c;

  assign tmo_hit_c = ((state == WAIT_HI) || (state == WAIT_LO)) && (tmo_cnt == '1);

  // Watchdog: restarts as the request leaves ISSUE, runs while waiting on ack.
  always_ff @(posedge fastclk) begin
    if (rst) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        tmo_cnt <= '0;
      end else if ((state == WAIT_HI) || (state == WAIT_LO)) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (tmo_hit_c) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  // TMO_W only sizes the watchdog; without it the flag is constant low.
  localparam bit HAS_TMO_W = (TMO_W != 0);
  assign timeout = HAS_TMO_W & 1'b0;
`endif

  // Next-state logic; the counter is decremented on the IDLE->ISSUE edge.
  always_comb begin
    state_next = state;
    release_c  = 1'b0;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          state_next = ISSUE;
          release_c  = 1'b1;
        end
      end
      ISSUE:   state_next = WAIT_HI;
      WAIT_HI: if (ack_pulse)  state_next = WAIT_LO;
      WAIT_LO: if (!ack_pulse) state_next = IDLE;
      default: state_next = IDLE;
    endcase
`ifdef FAST_EVENT_PACER_TIMEOUT_EN
    if (tmo_hit_c) begin
      state_next = IDLE;
    end
`endif
  end

  // State and registered request/busy outputs.
  always_ff @(posedge fastclk) begin
    if (rst) begin
      state         <= IDLE;
      fastpulse_out <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      fastpulse_out <= (state_next == ISSUE);
      busy          <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_fast_event_pacer.sv
// Bench for fast_event_pacer: directed vector table, converter-style ack
// responder, and a handshake-level reference model for random traffic.
module tb_fast_event_pacer;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO_W = 12;
  localparam int          MAXP  = (1 << CNT_W) - 1;

  logic             fastclk  = 1'b0;
  logic             slowclk  = 1'b0;
  logic             rst      = 1'b1;
  logic             event_in = 1'b0;
  logic             ack_pulse = 1'b0;
  logic             fastpulse_out;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             overflow;
  logic             timeout;

  fast_event_pacer #(
    .CNT_W(CNT_W),
    .TMO_W(TMO_W)
  ) dut (
    .fastclk       (fastclk),
    .rst           (rst),
    .event_in      (event_in),
    .ack_pulse     (ack_pulse),
    .fastpulse_out (fastpulse_out),
    .pending       (pending),
    .busy          (busy),
    .overflow      (overflow),
    .timeout       (timeout)
  );

  always #5   fastclk = ~fastclk;
  always #101 slowclk = ~slowclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Downstream converter stand-in: a request raises slowpulse for one slow period.
  bit resp_en   = 1'b0;
  bit ack_force = 1'b0;
  bit req       = 1'b0;
  bit slow_hi   = 1'b0;

  initial forever begin
    @(posedge slowclk);
    if (rst) begin
      slow_hi = 1'b0;
      req     = 1'b0;
    end else if (req) begin
      slow_hi = 1'b1;
      req     = 1'b0;
    end else begin
      slow_hi = 1'b0;
    end
  end

  initial forever begin
    @(posedge fastclk);
    #1;
    if (rst) req = 1'b0;
    else if (fastpulse_out) req = 1'b1;
  end

  initial forever begin
    @(negedge fastclk);
    #1;
    ack_pulse = resp_en ? slow_hi : ack_force;
  end

  // Reference model: queued count plus handshake progress (pulse cycle, then ack rise, then ack fall).
  bit check_en = 1'b0;
  int m_pend = 0, m_acks = 0, m_drops = 0, dut_pulses = 0;
  bit m_pulse = 1'b0, m_ovf = 1'b0;
  bit s_rst, s_ev, s_ack, s_rel;

  always @(posedge fastclk) begin
    s_rst = rst; s_ev = event_in; s_ack = ack_pulse; s_rel = 1'b0;
    if (s_rst) begin
      m_pend = 0; m_acks = 0; m_pulse = 1'b0; m_ovf = 1'b0;
    end else begin
      if (m_pulse) begin
        m_pulse = 1'b0;
        m_acks  = 2;
      end else if (m_acks == 2) begin
        if (s_ack) m_acks = 1;
      end else if (m_acks == 1) begin
        if (!s_ack) m_acks = 0;
      end else if (m_pend > 0) begin
        s_rel   = 1'b1;
        m_pulse = 1'b1;
      end
      if (s_ev && !s_rel) begin
        if (m_pend == MAXP) begin
          m_ovf = 1'b1;
          m_drops++;
        end else m_pend++;
      end else if (s_rel && !s_ev) begin
        m_pend--;
      end
    end
    #1;
    if (fastpulse_out) dut_pulses++;
    if (check_en) begin
      check("model pending", int'(pending), m_pend);
      check("model fastpulse_out", int'(fastpulse_out), int'(m_pulse));
      check("model busy", int'(busy), int'(m_pulse || (m_acks > 0)));
      check("model overflow", int'(overflow), int'(m_ovf));
      check("model timeout", int'(timeout), 0);
    end
  end

  int peak = 0;
  always @(negedge fastclk) if (int'(pending) > peak) peak = int'(pending);

  task automatic wait_idle(input int maxc, input string name);
    int c = 0;
    while ((busy || (pending != '0)) && (c < maxc)) begin
      @(negedge fastclk);
      c++;
    end
    check({name, " drained"}, int'(busy || (pending != '0)), 0);
  endtask

  typedef struct {
    bit rst;
    bit ev;
    bit ack;
    int p;
    bit f;
    bit b;
  } vec_t;

  localparam int NV = 27;
  vec_t tv[NV];

  initial begin
    #2ms;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int base, drops0;
    int rates[4];
    rates = '{5, 30, 90, 60};

    // rst ev ack | pending pulse busy
    tv[0]  = '{1, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 1, 0, 1, 0, 0};
    tv[2]  = '{0, 0, 0, 0, 1, 1};
    tv[3]  = '{0, 0, 1, 0, 0, 1};
    tv[4]  = '{0, 0, 1, 0, 0, 1};
    tv[5]  = '{0, 0, 0, 0, 0, 0};
    tv[6]  = '{0, 1, 0, 1, 0, 0};
    tv[7]  = '{0, 1, 0, 1, 1, 1};
    tv[8]  = '{0, 1, 0, 2, 0, 1};
    tv[9]  = '{0, 1, 1, 3, 0, 1};
    tv[10] = '{0, 0, 0, 3, 0, 0};
    tv[11] = '{0, 1, 0, 3, 1, 1};
    tv[12] = '{0, 0, 1, 3, 0, 1};
    tv[13] = '{0, 0, 1, 3, 0, 1};
    tv[14] = '{0, 0, 0, 3, 0, 0};
    tv[15] = '{0, 0, 0, 2, 1, 1};
    tv[16] = '{0, 1, 0, 3, 0, 1};
    tv[17] = '{0, 1, 0, 4, 0, 1};
    tv[18] = '{0, 1, 0, 5, 0, 1};
    tv[19] = '{0, 1, 0, 6, 0, 1};
    tv[20] = '{1, 1, 0, 0, 0, 0};
    tv[21] = '{0, 1, 0, 1, 0, 0};
    tv[22] = '{0, 0, 0, 0, 1, 1};
    tv[23] = '{0, 0, 1, 0, 0, 1};
    tv[24] = '{0, 0, 1, 0, 0, 1};
    tv[25] = '{0, 0, 0, 0, 0, 0};
    tv[26] = '{0, 0, 0, 0, 0, 0};

    for (int i = 0; i < NV; i++) begin
      @(negedge fastclk);
      rst = tv[i].rst; event_in = tv[i].ev; ack_force = tv[i].ack;
      @(posedge fastclk);
      #1;
      check($sformatf("vec%0d pending", i), int'(pending), tv[i].p);
      check($sformatf("vec%0d fastpulse_out", i), int'(fastpulse_out), int'(tv[i].f));
      check($sformatf("vec%0d busy", i), int'(busy), int'(tv[i].b));
      check($sformatf("vec%0d overflow", i), int'(overflow), 0);
      check($sformatf("vec%0d timeout", i), int'(timeout), 0);
    end

    // Model-checked phase with the converter responder.
    @(negedge fastclk);
    rst = 1'b1; event_in = 1'b0; ack_force = 1'b0; resp_en = 1'b1; check_en = 1'b1;
    @(negedge fastclk);
    rst = 1'b0;
    repeat (3) @(negedge fastclk);

    // Single event: pending at N+1, request at N+2.
    base = dut_pulses;
    event_in = 1'b1;
    @(negedge fastclk);
    event_in = 1'b0;
    check("single pending at N+1", int'(pending), 1);
    @(negedge fastclk);
    check("single request at N+2", int'(fastpulse_out), 1);
    wait_idle(300, "single");
    check("single pulse count", dut_pulses - base, 1);

    // Burst of 5.
    base = dut_pulses; peak = 0;
    repeat (5) begin
      event_in = 1'b1;
      @(negedge fastclk);
    end
    event_in = 1'b0;
    wait_idle(1000, "burst5");
    check("burst5 pulse count", dut_pulses - base, 5);
    check("burst5 peak 4 or 5", int'((peak >= 4) && (peak <= 5)), 1);
    check("burst5 overflow", int'(overflow), 0);

    // Burst of 20 saturates the queue.
    base = dut_pulses; drops0 = m_drops; peak = 0;
    repeat (20) begin
      event_in = 1'b1;
      @(negedge fastclk);
    end
    event_in = 1'b0;
    wait_idle(2000, "burst20");
    check("burst20 pulse count", dut_pulses - base, 20 - (m_drops - drops0));
    check("burst20 peak", peak, MAXP);
    check("burst20 overflow set", int'(overflow), 1);
    repeat (10) @(negedge fastclk);
    check("burst20 overflow sticky", int'(overflow), 1);
    rst = 1'b1;
    @(negedge fastclk);
    rst = 1'b0;
    check("overflow cleared by rst", int'(overflow), 0);

    // Random traffic at several rates with rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge fastclk);
      event_in = ($urandom_range(0, 99) < rates[i / 750]);
      rst      = ($urandom_range(0, 999) == 0);
    end
    @(negedge fastclk);
    event_in = 1'b0; rst = 1'b0;
    wait_idle(3000, "random");

`ifdef FAST_EVENT_PACER_TIMEOUT_EN
    // Ack never arrives: watchdog frees the FSM and the next event is issued.
    check_en = 1'b0; resp_en = 1'b0; ack_force = 1'b0;
    @(negedge fastclk);
    rst = 1'b1;
    @(negedge fastclk);
    rst = 1'b0; event_in = 1'b1;
    @(negedge fastclk);
    @(negedge fastclk);
    event_in = 1'b0;
    begin
      int c = 0;
      while (!timeout && (c < (1 << TMO_W) + 50)) begin
        @(negedge fastclk);
        c++;
      end
    end
    check("timeout set", int'(timeout), 1);
    check("timeout busy dropped", int'(busy), 0);
    check("timeout next queued", int'(pending), 1);
    @(negedge fastclk);
    check("timeout next issued", int'(fastpulse_out), 1);
    check("timeout sticky", int'(timeout), 1);
`else
    check("timeout tied low", int'(timeout), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
